// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// start/done handshake, sticky overflow, and significant-digit count for blanking.
module bcd_convert_seq #(
  parameter  int BIN_W  = 33,
  parameter  int DIGITS = 10,
  localparam int CNT_W  = $clog2(BIN_W + 1),
  localparam int SD_W   = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bnum,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [SD_W-1:0]       sig_digits
);

  // Handshake: start is honoured only in IDLE (a start in SHIFT or FINISH is
  // dropped, not queued); done is a one-cycle pulse marking the result update.
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state;
  logic [BIN_W-1:0]    bin_sr;
  logic [4*DIGITS-1:0] acc;
  logic                ovf_acc;
  logic [CNT_W-1:0]    cnt;

  logic [4*DIGITS-1:0] acc_adj;
  logic [SD_W-1:0]     sd_next;

  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  // Highest nonzero digit wins; all-zero still shows one digit.
  always_comb begin
    sd_next = SD_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] != 4'd0) sd_next = SD_W'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      acc        <= '0;
      ovf_acc    <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      sig_digits <= SD_W'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bnum;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The bit leaving the top digit is the carry into a digit we don't keep.
          acc     <= {acc_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          ovf_acc <= ovf_acc | acc_adj[4*DIGITS-1];
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd        <= acc;
          overflow   <= ovf_acc;
          sig_digits <= sd_next;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
